// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if : one requester's command/response channel to dmem_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter : burst-limited round-robin arbiter sharing one single-port
//                data memory between the LSU (port0) and a DMA master (port1)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter #(
  parameter int DEPTH     = 1024,
  parameter int BURST_LEN = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_arbiter_if.slave    port0,
  dmem_arbiter_if.slave    port1,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wr_dat,
  output logic             rd_en,
  output logic             wr_en,
  input  wire logic [31:0] m_rd_dat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0]  BURST = 4'(BURST_LEN);
  localparam logic [31:0] LIMIT = 32'(DEPTH);

  state_t      state;
  logic [3:0]  bcnt;
  logic        last;
  logic        tag_valid;
  logic        tag_port;
  logic        tag_err;

  logic        gnt0;
  logic        gnt1;
  logic        granted;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      IDLE: begin
        if (port0.req && port1.req) begin
          gnt0 = last;
          gnt1 = !last;
        end else begin
          gnt0 = port0.req;
          gnt1 = port1.req;
        end
      end
      OWN0: begin
        if (port0.req && (!port1.req || bcnt < BURST)) gnt0 = 1'b1;
        else if (port1.req)                             gnt1 = 1'b1;
      end
      OWN1: begin
        if (port1.req && (!port0.req || bcnt < BURST)) gnt1 = 1'b1;
        else if (port0.req)                             gnt0 = 1'b1;
      end
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    granted   = gnt0 | gnt1;
    sel_we    = 1'b0;
    sel_addr  = 32'd0;
    sel_wdata = 32'd0;
    if (gnt0) begin
      sel_we    = port0.we;
      sel_addr  = port0.addr;
      sel_wdata = port0.wdata;
    end else if (gnt1) begin
      sel_we    = port1.we;
      sel_addr  = port1.addr;
      sel_wdata = port1.wdata;
    end
    in_range = (sel_addr < LIMIT);
  end

  assign m_addr   = sel_addr;
  assign m_wr_dat = sel_wdata;
  assign rd_en    = granted && !sel_we && in_range;
  assign wr_en    = granted &&  sel_we && in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bcnt      <= 4'd0;
      last      <= 1'b1;
      tag_valid <= 1'b0;
      tag_port  <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      if (gnt0) begin
        state <= OWN0;
        last  <= 1'b0;
        if (state == OWN0) bcnt <= (bcnt < BURST) ? bcnt + 4'd1 : bcnt;
        else               bcnt <= 4'd1;
      end else if (gnt1) begin
        state <= OWN1;
        last  <= 1'b1;
        if (state == OWN1) bcnt <= (bcnt < BURST) ? bcnt + 4'd1 : bcnt;
        else               bcnt <= 4'd1;
      end else begin
        state <= IDLE;
      end
      // Good writes produce no response; reads and errored writes do.
      tag_valid <= granted && (!sel_we || !in_range);
      tag_port  <= gnt1;
      tag_err   <= !in_range;
    end
  end

  assign port0.gnt    = gnt0;
  assign port1.gnt    = gnt1;
  assign port0.rvalid = tag_valid && !tag_port;
  assign port1.rvalid = tag_valid &&  tag_port;
  assign port0.err    = tag_valid && !tag_port && tag_err;
  assign port1.err    = tag_valid &&  tag_port && tag_err;
  assign port0.rdata  = (tag_valid && !tag_port && !tag_err) ? m_rd_dat : 32'd0;
  assign port1.rdata  = (tag_valid &&  tag_port && !tag_err) ? m_rd_dat : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed stimulus with a behavioural arbitration model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;
  localparam int DEPTH = 1024;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m_addr;
  logic [31:0] m_wr_dat;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] m_rd_dat = 32'd0;

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if p0 ();
  dmem_arbiter_if p1 ();

  dmem_arbiter #(.DEPTH(DEPTH), .BURST_LEN(BURST)) dut (
    .clk      (clk),
    .reset    (reset),
    .port0    (p0),
    .port1    (p1),
    .m_addr   (m_addr),
    .m_wr_dat (m_wr_dat),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .m_rd_dat (m_rd_dat)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT; idle cycles return junk to expose ungated rdata.
  logic [31:0] mem [0:1023] = '{5: 32'hDEADBEEF, default: 32'h0};
  always @(posedge clk) begin
    if (wr_en) mem[m_addr[9:0]] <= m_wr_dat;
    m_rd_dat <= rd_en ? mem[m_addr[9:0]] : 32'hA5A5A5A5;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who should win this cycle, and what response is owed next cycle.
  logic [31:0] ref_mem [0:1023] = '{5: 32'hDEADBEEF, default: 32'h0};
  int          owner = -1;
  int          run   = 0;
  int          lastp = 1;
  logic        pv = 1'b0, pe = 1'b0;
  int          pp = 0;
  logic [31:0] pd = 32'd0;

  always @(negedge clk) begin : model
    logic        rq [2];
    logic        wq [2];
    logic [31:0] aq [2];
    logic [31:0] dq [2];
    int          eg;
    logic        inr;
    logic [31:0] e_addr, e_wdat;
    logic        e_rd, e_wr;
    rq[0] = p0.req;   rq[1] = p1.req;
    wq[0] = p0.we;    wq[1] = p1.we;
    aq[0] = p0.addr;  aq[1] = p1.addr;
    dq[0] = p0.wdata; dq[1] = p1.wdata;
    if (!reset) begin
      owner = -1; run = 0; lastp = 1; pv = 1'b0;
    end
    eg = -1;
    if (reset) begin
      if (owner < 0) begin
        if (rq[0] && rq[1]) eg = 1 - lastp;
        else if (rq[0])     eg = 0;
        else if (rq[1])     eg = 1;
      end else if (rq[owner] && (!rq[1-owner] || run < BURST)) begin
        eg = owner;
      end else if (rq[1-owner]) begin
        eg = 1 - owner;
      end
    end
    inr    = (eg >= 0) ? (aq[eg] < DEPTH) : 1'b1;
    e_addr = (eg >= 0) ? aq[eg] : 32'd0;
    e_wdat = (eg >= 0) ? dq[eg] : 32'd0;
    e_rd   = (eg >= 0) && !wq[eg] && inr;
    e_wr   = (eg >= 0) &&  wq[eg] && inr;
    chk("gnt0", {31'd0, p0.gnt}, {31'd0, eg == 0});
    chk("gnt1", {31'd0, p1.gnt}, {31'd0, eg == 1});
    chk("m_addr", m_addr, e_addr);
    chk("m_wr_dat", m_wr_dat, e_wdat);
    chk("rd_en", {31'd0, rd_en}, {31'd0, e_rd});
    chk("wr_en", {31'd0, wr_en}, {31'd0, e_wr});
    chk("rvalid0", {31'd0, p0.rvalid}, {31'd0, pv && pp == 0});
    chk("rvalid1", {31'd0, p1.rvalid}, {31'd0, pv && pp == 1});
    chk("err0", {31'd0, p0.err}, {31'd0, pv && pp == 0 && pe});
    chk("err1", {31'd0, p1.err}, {31'd0, pv && pp == 1 && pe});
    chk("rdata0", p0.rdata, (pv && pp == 0 && !pe) ? pd : 32'd0);
    chk("rdata1", p1.rdata, (pv && pp == 1 && !pe) ? pd : 32'd0);
    if (reset) begin
      pv = (eg >= 0) && (!wq[eg] || !inr);
      pp = eg;
      pe = !inr;
      pd = e_rd ? ref_mem[e_addr[9:0]] : 32'd0;
      if (e_wr) ref_mem[e_addr[9:0]] = e_wdat;
      if (eg >= 0) begin
        run   = (eg == owner) ? ((run < BURST) ? run + 1 : run) : 1;
        owner = eg;
        lastp = eg;
      end else begin
        owner = -1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    p0.req = r; p0.we = w; p0.addr = a; p0.wdata = d;
  endtask

  task automatic cmd1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    p1.req = r; p1.we = w; p1.addr = a; p1.wdata = d;
  endtask

  logic [11:0] seq;

  initial begin
    cmd0(0, 0, 0, 0);
    cmd1(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // single read of a preloaded word
    cmd0(1, 0, 5, 0);
    @(negedge clk);
    chk("t1_gnt0", {31'd0, p0.gnt}, 32'd1);
    chk("t1_rd_en", {31'd0, rd_en}, 32'd1);
    chk("t1_addr", m_addr, 32'd5);
    step(); cmd0(0, 0, 0, 0);
    @(negedge clk);
    chk("t1_rvalid0", {31'd0, p0.rvalid}, 32'd1);
    chk("t1_rdata0", p0.rdata, 32'hDEADBEEF);
    chk("t1_err0", {31'd0, p0.err}, 32'd0);
    step();

    // write then read back through port 1
    cmd1(1, 1, 10, 32'h12345678);
    @(negedge clk);
    chk("t2_wr_en", {31'd0, wr_en}, 32'd1);
    chk("t2_addr", m_addr, 32'd10);
    step(); cmd1(1, 0, 10, 0);
    @(negedge clk);
    chk("t2_rvalid1_wr", {31'd0, p1.rvalid}, 32'd0);
    step(); cmd1(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_rvalid1", {31'd0, p1.rvalid}, 32'd1);
    chk("t2_rdata1", p1.rdata, 32'h12345678);
    step();

    // contention from reset
    reset = 1'b0;
    cmd0(1, 0, 20, 0);
    cmd1(1, 0, 21, 0);
    step(); reset = 1'b1;
    seq = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seq = {seq[10:0], p1.gnt};
      step();
    end
    chk("t3_grant_seq", {20'd0, seq}, {20'd0, 12'b000011110000});
    cmd0(0, 0, 0, 0); cmd1(0, 0, 0, 0);
    step();

    // out-of-range read and write
    cmd0(1, 0, 1024, 0);
    @(negedge clk);
    chk("t4_gnt0", {31'd0, p0.gnt}, 32'd1);
    chk("t4_rd_en", {31'd0, rd_en}, 32'd0);
    step(); cmd0(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_rvalid0", {31'd0, p0.rvalid}, 32'd1);
    chk("t4_err0", {31'd0, p0.err}, 32'd1);
    chk("t4_rdata0", p0.rdata, 32'd0);
    step(); cmd1(1, 1, 2000, 32'hCAFEF00D);
    @(negedge clk);
    chk("t4_wr_en", {31'd0, wr_en}, 32'd0);
    step(); cmd1(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_err1", {31'd0, p1.err}, 32'd1);
    step();
    @(negedge clk);
    chk("t4_err1_pulse", {31'd0, p1.err}, 32'd0);
    step();

    // reset between a read grant and its response edge
    cmd0(1, 0, 5, 0);
    @(negedge clk);
    chk("t5_gnt0", {31'd0, p0.gnt}, 32'd1);
    #2 reset = 1'b0;
    cmd1(1, 0, 7, 0);
    @(negedge clk);
    chk("t5_rvalid0", {31'd0, p0.rvalid}, 32'd0);
    chk("t5_gnt_any", {30'd0, p1.gnt, p0.gnt}, 32'd0);
    chk("t5_rd_en", {31'd0, rd_en}, 32'd0);
    step(); reset = 1'b1;
    @(negedge clk);
    chk("t5_tie_gnt0", {31'd0, p0.gnt}, 32'd1);
    chk("t5_tie_gnt1", {31'd0, p1.gnt}, 32'd0);
    chk("t5_no_stale", {31'd0, p0.rvalid}, 32'd0);
    step(); cmd0(0, 0, 0, 0); cmd1(0, 0, 0, 0);
    step();

    // early drop by the owner restarts the burst for port 1
    cmd0(1, 0, 3, 0);
    @(negedge clk);
    chk("t6_gnt0_a", {31'd0, p0.gnt}, 32'd1);
    step();
    @(negedge clk);
    chk("t6_gnt0_b", {31'd0, p0.gnt}, 32'd1);
    step(); cmd0(0, 0, 0, 0); cmd1(1, 0, 4, 0);
    @(negedge clk);
    chk("t6_gnt1_now", {31'd0, p1.gnt}, 32'd1);
    step(); cmd0(1, 0, 3, 0);
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq = {seq[10:0], p1.gnt};
      step();
    end
    chk("t6_burst_seq", {20'd0, seq}, 32'b1110);
    cmd0(0, 0, 0, 0); cmd1(0, 0, 0, 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
